// File: rtl/lcd_frame_scheduler.sv
// Frame-cadence scheduler for the LCD timing controller with double-buffer swap handshake.
// Optional repeated-frame counter enabled by defining LCD_SCHED_SKIP_CNT_EN.
module lcd_frame_scheduler #(
  parameter int FRAME_PERIOD   = 666667,
  parameter int TIMEOUT_CYCLES = 600000,
  parameter int CNT_W          = 20
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        i_enable,
  input  logic        i_frame_done,
  input  logic        i_render_done,
  output logic        o_start,
  output logic        o_busy,
  output logic        o_front_sel,
  output logic        o_back_free,
  output logic [15:0] o_frame_count,
  output logic        o_err,
  output logic [15:0] o_skip_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SWAP} state_t;

  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(FRAME_PERIOD - 1);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state, w_nxt;
  logic [CNT_W-1:0] r_pcnt, r_tcnt;
  logic             r_start, r_err, r_front, r_pending;
  logic [15:0]      r_fcnt;
  logic             w_tick, w_launch, w_timeout;

  // Free-running cadence counter; ticks are simply lost while a frame is in flight.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)                r_pcnt <= '0;
    else if (!i_enable)          r_pcnt <= '0;
    else if (r_pcnt == P_LAST)   r_pcnt <= '0;
    else                         r_pcnt <= r_pcnt + 1'b1;
  end

  assign w_tick = i_enable && (r_pcnt == P_LAST);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    w_launch  = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: if (w_tick) begin
        w_launch = 1'b1;
        w_nxt    = S_RUN;
      end
      // Frame-done takes priority over a same-cycle timeout.
      S_RUN: if (i_frame_done) begin
        w_nxt = S_SWAP;
      end else if (r_tcnt == T_LAST) begin
        w_timeout = 1'b1;
        w_nxt     = S_IDLE;
      end
      S_SWAP:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_start   <= 1'b0;
      r_tcnt    <= '0;
      r_err     <= 1'b0;
      r_fcnt    <= '0;
      r_front   <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_start <= w_launch;
      if (w_launch)              r_tcnt <= '0;
      else if (r_state == S_RUN) r_tcnt <= r_tcnt + 1'b1;
      if (w_timeout)             r_err  <= 1'b1;
      if (r_state == S_SWAP)     r_fcnt <= r_fcnt + 1'b1;
      // A render completing during a no-swap SWAP is kept for the next frame.
      if (r_state == S_SWAP && r_pending) begin
        r_front   <= ~r_front;
        r_pending <= 1'b0;
      end else if (i_render_done && !r_pending) begin
        r_pending <= 1'b1;
      end
    end
  end

`ifdef LCD_SCHED_SKIP_CNT_EN
  logic [15:0] r_skip;
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)
      r_skip <= '0;
    else if (r_state == S_SWAP && !r_pending && r_skip != 16'hFFFF)
      r_skip <= r_skip + 1'b1;
  end
  assign o_skip_count = r_skip;
`else
  assign o_skip_count = 16'd0;
`endif

  assign o_start       = r_start;
  assign o_busy        = (r_state != S_IDLE);
  assign o_front_sel   = r_front;
  assign o_back_free   = ~r_pending;
  assign o_frame_count = r_fcnt;
  assign o_err         = r_err;

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Directed bench for lcd_frame_scheduler at FRAME_PERIOD=100, TIMEOUT_CYCLES=50.
module tb_lcd_frame_scheduler;
  logic        clk = 1'b0;
  logic        aresetn;
  logic        i_enable, i_frame_done, i_render_done;
  logic        o_start, o_busy, o_front_sel, o_back_free, o_err;
  logic [15:0] o_frame_count, o_skip_count;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int t_start, t0, w, n;

`ifdef LCD_SCHED_SKIP_CNT_EN
  localparam int SK1 = 1;
  localparam int SK2 = 2;
`else
  localparam int SK1 = 0;
  localparam int SK2 = 0;
`endif

  lcd_frame_scheduler #(.FRAME_PERIOD(100), .TIMEOUT_CYCLES(50), .CNT_W(8)) dut (
    .clk(clk), .aresetn(aresetn), .i_enable(i_enable), .i_frame_done(i_frame_done),
    .i_render_done(i_render_done), .o_start(o_start), .o_busy(o_busy),
    .o_front_sel(o_front_sel), .o_back_free(o_back_free), .o_frame_count(o_frame_count),
    .o_err(o_err), .o_skip_count(o_skip_count)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk); #1;
      cyc_cnt++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input int limit, output int waited);
    waited = 0;
    while (o_start !== 1'b1 && waited < limit) begin
      cyc(1);
      waited++;
    end
  endtask

  task automatic pulse_done();
    i_frame_done = 1'b1; cyc(1); i_frame_done = 1'b0;
  endtask

  task automatic pulse_render();
    i_render_done = 1'b1; cyc(1); i_render_done = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_start"}, o_start, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_front"}, o_front_sel, 0);
    chk({tag, "_backfree"}, o_back_free, 1);
    chk({tag, "_fcnt"}, o_frame_count, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_skip"}, o_skip_count, 0);
  endtask

  initial begin
    aresetn = 1'b0; i_enable = 1'b0; i_frame_done = 1'b0; i_render_done = 1'b0;
    #22;
    chk_reset("rst");
    aresetn = 1'b1;
    cyc(3);

    // 1: first start one full period after enable
    i_enable = 1'b1;
    t0 = cyc_cnt;
    wait_start(300, w);
    chk("first_start_lat", cyc_cnt - t0, 100);
    chk("first_busy", o_busy, 1);
    t_start = cyc_cnt;
    cyc(1);
    chk("start_one_cycle", o_start, 0);
    chk("run_busy", o_busy, 1);

    // 2: frame done with no render -> repeat frame
    cyc(18);
    pulse_done();
    chk("swap_busy", o_busy, 1);
    chk("swap_fcnt_pre", o_frame_count, 0);
    cyc(1);
    chk("f1_fcnt", o_frame_count, 1);
    chk("f1_front", o_front_sel, 0);
    chk("f1_backfree", o_back_free, 1);
    chk("f1_busy", o_busy, 0);
    chk("f1_skip", o_skip_count, SK1);

    // 3: render done mid-frame -> swap at frame end
    wait_start(300, w);
    chk("period2", cyc_cnt - t_start, 100);
    t_start = cyc_cnt;
    cyc(5);
    pulse_render();
    chk("rd_backfree", o_back_free, 0);
    cyc(3);
    pulse_render();
    chk("rd2_backfree", o_back_free, 0);
    chk("rd2_front", o_front_sel, 0);
    cyc(3);
    pulse_done();
    chk("swap2_backfree", o_back_free, 0);
    chk("swap2_front", o_front_sel, 0);
    cyc(1);
    chk("f2_front", o_front_sel, 1);
    chk("f2_backfree", o_back_free, 1);
    chk("f2_fcnt", o_frame_count, 2);
    chk("f2_skip", o_skip_count, SK1);

    // 4: timeout
    wait_start(300, w);
    chk("period3", cyc_cnt - t_start, 100);
    t_start = cyc_cnt;
    n = 0;
    while (o_err !== 1'b1 && n < 200) begin
      cyc(1);
      n++;
    end
    chk("timeout_lat", n, 50);
    chk("timeout_busy", o_busy, 0);
    chk("timeout_fcnt", o_frame_count, 2);
    chk("timeout_front", o_front_sel, 1);
    wait_start(300, w);
    chk("restart_after_to", cyc_cnt - t_start, 100);
    chk("err_sticky", o_err, 1);

    // 5: enable falls mid-frame
    cyc(5);
    i_enable = 1'b0;
    cyc(5);
    pulse_done();
    chk("dis_swap_busy", o_busy, 1);
    cyc(1);
    chk("dis_fcnt", o_frame_count, 3);
    chk("dis_front", o_front_sel, 1);
    chk("dis_skip", o_skip_count, SK2);
    chk("dis_busy", o_busy, 0);
    pulse_done();
    cyc(2);
    chk("idle_done_ignored", o_frame_count, 3);
    n = 0;
    repeat (350) begin
      cyc(1);
      if (o_start === 1'b1) n++;
    end
    chk("no_start_disabled", n, 0);

    // 6: async reset mid-frame with pending set
    i_enable = 1'b1;
    wait_start(300, w);
    chk("reen_start", o_start, 1);
    cyc(3);
    pulse_render();
    chk("pre_rst_backfree", o_back_free, 0);
    cyc(2);
    #3 aresetn = 1'b0;
    #1;
    chk_reset("async_rst");
    #2 aresetn = 1'b1;
    cyc(2);
    chk("post_rst_backfree", o_back_free, 1);
    chk("post_rst_front", o_front_sel, 0);
    chk("post_rst_busy", o_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
